// File: rtl/neureka_infeat_buffer_loader.sv
// Write-side sequencer for the input-feature buffer SCM: streams words into
// addresses 0..count-1, inserting zero words for padded slots, with optional broadcast clear.
`timescale 1ns/1ps
module neureka_infeat_buffer_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   num_words_i,
    input  logic [NUM_WORDS-1:0]  pad_mask_i,
    input  logic                  zero_init_i,
    input  logic                  load_valid_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_ready_o,
    output logic                  buf_clear_o,
    output logic                  buf_we_o,
    output logic                  buf_we_all_o,
    output logic [ADDR_WIDTH-1:0] buf_waddr_o,
    output logic [DATA_WIDTH-1:0] buf_wdata_o,
    output logic                  busy_o,
    output logic                  done_o
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]  MAX_COUNT = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [NUM_WORDS-1:0] PAD_BIT0  = NUM_WORDS'(1);

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [NUM_WORDS-1:0]  pad_reg;
    logic                  buf_clear_reg;
    logic                  buf_we_reg;
    logic                  buf_we_all_reg;
    logic [ADDR_WIDTH-1:0] buf_waddr_reg;
    logic [DATA_WIDTH-1:0] buf_wdata_reg;

    logic                  pad_cur;
    logic                  wr_event;
    logic                  last_word;
    logic [ADDR_WIDTH:0]   start_count;

    assign pad_cur      = |(pad_reg & (PAD_BIT0 << idx_reg));
    assign load_ready_o = (state_reg == LOAD) && !pad_cur;
    // Padded slots write unconditionally; real slots wait for a stream beat.
    assign wr_event     = (state_reg == LOAD) && (pad_cur || load_valid_i);
    assign last_word    = ({1'b0, idx_reg} == (count_reg - (ADDR_WIDTH+1)'(1)));
    assign start_count  = (num_words_i > MAX_COUNT) ? MAX_COUNT : num_words_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            count_reg      <= '0;
            pad_reg        <= '0;
            buf_clear_reg  <= 1'b0;
            buf_we_reg     <= 1'b0;
            buf_we_all_reg <= 1'b0;
            buf_waddr_reg  <= '0;
            buf_wdata_reg  <= '0;
        end else begin
            buf_clear_reg  <= 1'b0;
            buf_we_reg     <= 1'b0;
            buf_we_all_reg <= 1'b0;
            if (clear_i) begin
                state_reg     <= IDLE;
                idx_reg       <= '0;
                buf_clear_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_i) begin
                            count_reg <= start_count;
                            pad_reg   <= pad_mask_i;
                            idx_reg   <= '0;
                            state_reg <= (start_count == '0) ? DONE : LOAD;
                            if (zero_init_i) begin
                                buf_we_all_reg <= 1'b1;
                                buf_wdata_reg  <= '0;
                            end
                        end
                    end
                    LOAD: begin
                        if (wr_event) begin
                            buf_we_reg    <= 1'b1;
                            buf_waddr_reg <= idx_reg;
                            buf_wdata_reg <= pad_cur ? '0 : load_data_i;
                            idx_reg       <= idx_reg + ADDR_WIDTH'(1);
                            if (last_word) begin
                                state_reg <= DONE;
                            end
                        end
                    end
                    DONE:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign buf_clear_o  = buf_clear_reg;
    assign buf_we_o     = buf_we_reg;
    assign buf_we_all_o = buf_we_all_reg;
    assign buf_waddr_o  = buf_waddr_reg;
    assign buf_wdata_o  = buf_wdata_reg;
    assign busy_o       = (state_reg != IDLE);
    assign done_o       = (state_reg == DONE);
endmodule
